// File: rtl/ssd1306_pkg.sv
// +----------------------------------------------------------------------------+
// | ssd1306_pkg : opcodes, addressing/FSM enums and argument-count lookup      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package ssd1306_pkg;

  localparam logic [7:0] OP_SET_MODE  = 8'h20;
  localparam logic [7:0] OP_COL_ADDR  = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
  localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
  localparam logic [7:0] OP_DISP_ON   = 8'hAF;

  typedef enum logic [1:0] {
    MODE_HORIZ = 2'b00,
    MODE_VERT  = 2'b01,
    MODE_PAGE  = 2'b10
  } addr_mode_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ARG  = 1'b1
  } cmd_state_e;

  function automatic logic [2:0] arg_count(input logic [7:0] op);
    case (op)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB: arg_count = 3'd1;
      8'h21, 8'h22, 8'hA3:        arg_count = 3'd2;
      8'h29, 8'h2A:               arg_count = 3'd5;
      8'h26, 8'h27:               arg_count = 3'd6;
      default:                    arg_count = 3'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_byte_rx.sv
// +----------------------------------------------------------------------------+
// | spi_byte_rx : oversampling SPI mode-0 byte receiver with CS# framing check |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       csn_in,
  input  logic       dc_in,
  input  logic       sclk_in,
  input  logic       mosi_in,
  output logic [7:0] byte_out,
  output logic       dc_out,
  output logic       valid_out,
  output logic       err_out
);

  localparam int CSN  = 3;
  localparam int DC   = 2;
  localparam int SCLK = 1;
  localparam int MOSI = 0;
  localparam logic [3:0] SYNC_RST = 4'b1000;

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0] s;
  logic [1:0] prev_q, prev_d;   // {csn, sclk} one sample behind s
  logic [6:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       sclk_rise;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {csn_in, dc_in, sclk_in, mosi_in}};
    s      = sync_q[SYNC_STAGES-1];
    prev_d = {s[CSN], s[SCLK]};
    // CS# is qualified one sample late so a CS# rise coincident with the
    // final SCLK edge still completes the byte.
    sclk_rise = s[SCLK] & ~prev_q[0] & ~prev_q[1];

    shift_d   = shift_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    valid_out = 1'b0;
    if (sclk_rise) begin
      shift_d = {shift_q[5:0], s[MOSI]};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        valid_out = 1'b1;
      end
    end else if (s[CSN]) begin
      cnt_d = 3'd0;
      if (cnt_q != 3'd0) begin
        err_d = 1'b1;
      end
    end
    byte_out = {shift_q, s[MOSI]};
    dc_out   = s[DC];
    err_out  = err_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sync_q  <= {SYNC_STAGES{SYNC_RST}};
      prev_q  <= 2'b10;
      shift_q <= '0;
      cnt_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ssd1306_spi_sink.sv
// +----------------------------------------------------------------------------+
// | ssd1306_spi_sink : SSD1306 4-wire SPI receiver, command decode, GDDRAM ptr |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ssd1306_spi_sink
  import ssd1306_pkg::*;
#(
  parameter int COLS        = 128,
  parameter int PAGES       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  input  logic                          oled_csn_in,
  input  logic                          oled_dc_in,
  input  logic                          oled_clk_in,
  input  logic                          oled_mosi_in,
  output logic                          byte_valid_out,
  output logic [7:0]                    byte_out,
  output logic                          byte_is_data_out,
  output logic                          fb_we_out,
  output logic [$clog2(COLS*PAGES)-1:0] fb_addr_out,
  output logic [7:0]                    fb_data_out,
  output logic                          display_on_out,
  output logic                          frame_done_out,
  output logic                          proto_err_out
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);
  localparam int AW = $clog2(COLS*PAGES);

  logic [7:0] rx_byte;
  logic       rx_dc, rx_valid, rx_err;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .csn_in    (oled_csn_in),
    .dc_in     (oled_dc_in),
    .sclk_in   (oled_clk_in),
    .mosi_in   (oled_mosi_in),
    .byte_out  (rx_byte),
    .dc_out    (rx_dc),
    .valid_out (rx_valid),
    .err_out   (rx_err)
  );

  function automatic logic [CW-1:0] clamp_col(input logic [7:0] a);
    if (int'(a) > COLS - 1) return CW'(COLS - 1);
    else                    return a[CW-1:0];
  endfunction

  cmd_state_e    state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [2:0]    left_q, left_d;
  logic [7:0]    arg_q, arg_d;
  addr_mode_e    mode_q, mode_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic          disp_q, disp_d;
  logic          byte_valid_q, byte_valid_d, byte_dc_q, byte_dc_d;
  logic [7:0]    byte_q, byte_d, fb_data_q, fb_data_d;
  logic          fb_we_q, fb_we_d, frame_q, frame_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic [CW-1:0] adv_col;
  logic [PW-1:0] adv_page;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    left_d       = left_q;
    arg_d        = arg_q;
    mode_d       = mode_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    disp_d       = disp_q;
    byte_d       = byte_q;
    byte_dc_d    = byte_dc_q;
    fb_data_d    = fb_data_q;
    fb_addr_d    = fb_addr_q;
    byte_valid_d = 1'b0;
    fb_we_d      = 1'b0;
    frame_d      = 1'b0;

    adv_col  = (col_q == col_end_q)   ? col_start_q  : col_q + CW'(1);
    adv_page = (page_q == page_end_q) ? page_start_q : page_q + PW'(1);

    if (rx_valid) begin
      byte_valid_d = 1'b1;
      byte_d       = rx_byte;
      byte_dc_d    = rx_dc;
      if (rx_dc) begin
        state_d   = IDLE;
        fb_we_d   = 1'b1;
        fb_data_d = rx_byte;
        fb_addr_d = AW'(page_q) * AW'(COLS) + AW'(col_q);
        frame_d   = (col_q == col_end_q) && (page_q == page_end_q);
        case (mode_q)
          MODE_HORIZ: begin
            col_d = adv_col;
            if (col_q == col_end_q) page_d = adv_page;
          end
          MODE_VERT: begin
            page_d = adv_page;
            if (page_q == page_end_q) col_d = adv_col;
          end
          default: col_d = adv_col;
        endcase
      end else if (state_q == ARG) begin
        // arg_q always holds the previous argument, i.e. the first of a pair.
        arg_d  = rx_byte;
        left_d = left_q - 3'd1;
        if (left_q == 3'd1) begin
          state_d = IDLE;
          case (op_q)
            OP_SET_MODE: begin
              if (rx_byte[1:0] != 2'b11) mode_d = addr_mode_e'(rx_byte[1:0]);
            end
            OP_COL_ADDR: begin
              col_start_d = clamp_col(arg_q);
              col_end_d   = clamp_col(rx_byte);
              col_d       = clamp_col(arg_q);
            end
            OP_PAGE_ADDR: begin
              page_start_d = arg_q[PW-1:0];
              page_end_d   = rx_byte[PW-1:0];
              page_d       = arg_q[PW-1:0];
            end
            default: ;
          endcase
        end
      end else if (arg_count(rx_byte) != 3'd0) begin
        state_d = ARG;
        op_d    = rx_byte;
        left_d  = arg_count(rx_byte);
      end else if (rx_byte == OP_DISP_ON) begin
        disp_d = 1'b1;
      end else if (rx_byte == OP_DISP_OFF) begin
        disp_d = 1'b0;
      end else if (rx_byte[7:3] == 5'b10110) begin
        page_d = rx_byte[PW-1:0];
      end else if (rx_byte[7:5] == 3'b000 && mode_q == MODE_PAGE) begin
        if (rx_byte[4]) col_d[CW-1:4] = rx_byte[CW-5:0];
        else            col_d[3:0]    = rx_byte[3:0];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      op_q         <= 8'h00;
      left_q       <= 3'd0;
      arg_q        <= 8'h00;
      mode_q       <= MODE_PAGE;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(COLS - 1);
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
      disp_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'h00;
      byte_dc_q    <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= 8'h00;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      left_q       <= left_d;
      arg_q        <= arg_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      disp_q       <= disp_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      byte_dc_q    <= byte_dc_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      frame_q      <= frame_d;
    end
  end

  assign byte_valid_out   = byte_valid_q;
  assign byte_out         = byte_q;
  assign byte_is_data_out = byte_dc_q;
  assign fb_we_out        = fb_we_q;
  assign fb_addr_out      = fb_addr_q;
  assign fb_data_out      = fb_data_q;
  assign display_on_out   = disp_q;
  assign frame_done_out   = frame_q;
  assign proto_err_out    = rx_err;

endmodule

`default_nettype wire

// File: tb/tb_ssd1306_spi_sink.sv
// +----------------------------------------------------------------------------+
// | tb_ssd1306_spi_sink : bit-banged SPI stimulus against a behavioural model  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ssd1306_spi_sink;

  localparam int COLS  = 128;
  localparam int PAGES = 8;
  localparam int SYNC  = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic csn = 1'b1, dc = 1'b0, sclk = 1'b0, mosi = 1'b0;
  logic       byte_valid_out, byte_is_data_out, fb_we_out;
  logic [7:0] byte_out, fb_data_out;
  logic [9:0] fb_addr_out;
  logic       display_on_out, frame_done_out, proto_err_out;

  always #5 clk = ~clk;

  ssd1306_spi_sink #(.COLS(COLS), .PAGES(PAGES), .SYNC_STAGES(SYNC)) dut (
    .clk_in           (clk),
    .reset_in         (rst),
    .oled_csn_in      (csn),
    .oled_dc_in       (dc),
    .oled_clk_in      (sclk),
    .oled_mosi_in     (mosi),
    .byte_valid_out   (byte_valid_out),
    .byte_out         (byte_out),
    .byte_is_data_out (byte_is_data_out),
    .fb_we_out        (fb_we_out),
    .fb_addr_out      (fb_addr_out),
    .fb_data_out      (fb_data_out),
    .display_on_out   (display_on_out),
    .frame_done_out   (frame_done_out),
    .proto_err_out    (proto_err_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Observed strobes, captured between clock edges.
  int obs_b[$];
  int obs_w[$];
  always @(posedge clk) begin
    #1;
    if (byte_valid_out) obs_b.push_back({byte_is_data_out, byte_out});
    if (fb_we_out || frame_done_out)
      obs_w.push_back({fb_we_out, frame_done_out, fb_addr_out, fb_data_out});
  end

  // Reference model of the display controller's addressing behaviour.
  int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_disp, m_err, m_op, m_left;
  int m_args[$];
  int exp_b[$];
  int exp_w[$];

  task automatic model_reset();
    m_mode = 2; m_col = 0; m_page = 0;
    m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
    m_disp = 0; m_err = 0; m_op = 0; m_left = 0;
    m_args.delete(); exp_b.delete(); exp_w.delete();
  endtask

  function automatic int n_args(input int op);
    case (op)
      'h20, 'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB: return 1;
      'h21, 'h22, 'hA3: return 2;
      'h29, 'h2A:       return 5;
      'h26, 'h27:       return 6;
      default:          return 0;
    endcase
  endfunction

  function automatic int min_col(input int v);
    return (v > COLS - 1) ? COLS - 1 : v;
  endfunction

  task automatic model_byte(input int is_data, input int b);
    exp_b.push_back((is_data << 8) | b);
    if (is_data != 0) begin
      m_left = 0;
      exp_w.push_back((1 << 19) | (((m_col == m_ce && m_page == m_pe) ? 1 : 0) << 18)
                      | ((m_page * COLS + m_col) << 8) | b);
      if (m_mode == 0) begin
        if (m_col == m_ce) begin
          m_col  = m_cs;
          m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
        end else m_col = (m_col + 1) % COLS;
      end else if (m_mode == 1) begin
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_col  = (m_col == m_ce) ? m_cs : (m_col + 1) % COLS;
        end else m_page = (m_page + 1) % PAGES;
      end else begin
        m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % COLS;
      end
    end else if (m_left > 0) begin
      m_args.push_back(b);
      m_left--;
      if (m_left == 0) begin
        if (m_op == 'h20 && (m_args[0] & 3) != 3) m_mode = m_args[0] & 3;
        if (m_op == 'h21) begin
          m_cs = min_col(m_args[0]); m_ce = min_col(m_args[1]); m_col = m_cs;
        end
        if (m_op == 'h22) begin
          m_ps = m_args[0] & 7; m_pe = m_args[1] & 7; m_page = m_ps;
        end
      end
    end else if (n_args(b) > 0) begin
      m_op = b; m_left = n_args(b); m_args.delete();
    end else if (b == 'hAF) m_disp = 1;
    else if (b == 'hAE) m_disp = 0;
    else if (b >= 'hB0 && b <= 'hB7) m_page = b & 7;
    else if (b < 'h10 && m_mode == 2) m_col = (m_col & ~15) | (b & 15);
    else if (b < 'h20 && m_mode == 2) m_col = (((b & 15) << 4) | (m_col & 15)) % COLS;
  endtask

  task automatic verify(input string tag);
    check({tag, ".nbyte"}, obs_b.size(), exp_b.size());
    check({tag, ".nwrite"}, obs_w.size(), exp_w.size());
    while (obs_b.size() > 0 && exp_b.size() > 0)
      check({tag, ".byte"}, obs_b.pop_front(), exp_b.pop_front());
    while (obs_w.size() > 0 && exp_w.size() > 0)
      check({tag, ".write"}, obs_w.pop_front(), exp_w.pop_front());
    obs_b.delete(); obs_w.delete(); exp_b.delete(); exp_w.delete();
    check({tag, ".disp"}, display_on_out, m_disp);
    check({tag, ".err"}, proto_err_out, m_err);
  endtask

  int half = 4;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input int b, input int nbits, input int is_data, input bit cs_fast);
    dc  = is_data[0];
    csn = 1'b0;
    tick(half);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      tick(half);
      sclk = 1'b1;
      if (cs_fast && i == 0) csn = 1'b1;
      tick(half);
      sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input int is_data, input int b, input bit hold, input bit cs_fast);
    send_bits(b, 8, is_data, cs_fast);
    tick(SYNC + 3);
    if (!hold) begin
      csn = 1'b1;
      tick(2);
    end
    model_byte(is_data, b);
    verify(is_data != 0 ? "data" : "cmd");
  endtask

  task automatic cmd(input int b);
    send_byte(0, b, 1'b0, 1'b0);
  endtask

  task automatic dat(input int b);
    send_byte(1, b, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, byte_valid_out, 0);
    check({tag, ".byte"}, byte_out, 0);
    check({tag, ".isdata"}, byte_is_data_out, 0);
    check({tag, ".we"}, fb_we_out, 0);
    check({tag, ".addr"}, fb_addr_out, 0);
    check({tag, ".fbdata"}, fb_data_out, 0);
    check({tag, ".disp"}, display_on_out, 0);
    check({tag, ".frame"}, frame_done_out, 0);
    check({tag, ".err"}, proto_err_out, 0);
  endtask

  int exp_addr[5] = '{130, 131, 258, 259, 130};
  int pick_tbl[14] = '{'h20, 'h21, 'h22, 'hAE, 'hAF, 'h81, 'hB0, 'h05,
                       'h13, 'hA3, 'h26, 'h29, 'h8D, 'hE3};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    tick(6);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(4);

    dat('hA5);
    check("first.addr", fb_addr_out, 0);
    check("first.data", fb_data_out, 'hA5);
    dat('h5A);
    check("second.addr", fb_addr_out, 1);

    cmd('h20); cmd('h00);
    cmd('h21); cmd('h02); cmd('h03);
    cmd('h22); cmd('h01); cmd('h02);
    for (int i = 0; i < 5; i++) begin
      dat('h10 + i);
      check("horiz.addr", fb_addr_out, exp_addr[i]);
    end

    cmd('h20); cmd('h02);
    cmd('hB3); cmd('h05); cmd('h11);
    dat('h3C);
    check("page.addr", fb_addr_out, 405);

    cmd('h81); cmd('hAF);
    check("contrast.disp", display_on_out, 0);
    cmd('hAF);
    check("on.disp", display_on_out, 1);
    cmd('hAE);
    check("off.disp", display_on_out, 0);

    // ARG aborted by a data byte: the byte is still written.
    cmd('h21); cmd('h07); dat('h66);

    send_bits('hFF, 5, 1, 1'b0);
    tick(2);
    csn = 1'b1;
    tick(SYNC + 4);
    m_err = 1;
    verify("partial");
    dat('h0F);
    check("partial.err", proto_err_out, 1);
    check("partial.byte", byte_out, 'h0F);

    send_byte(1, 'h77, 1'b0, 1'b1);

    cmd('h20); cmd('h00);
    send_bits('hC3, 4, 1, 1'b0);
    rst = 1'b1;
    tick(2);
    csn = 1'b1; sclk = 1'b0;
    tick(SYNC + 3);
    check_reset_outputs("midreset");
    rst = 1'b0;
    tick(2);
    model_reset();
    obs_b.delete(); obs_w.delete();
    dat('h81);
    check("postreset.addr", fb_addr_out, 0);

    for (int k = 0; k < 250; k++) begin
      int is_data, b;
      bit hold, fast;
      half    = $urandom_range(2, 4);
      hold    = ($urandom_range(0, 2) == 0);
      fast    = !hold && ($urandom_range(0, 7) == 0);
      is_data = ($urandom_range(0, 2) == 0) ? 1 : 0;
      if (is_data != 0 || m_left > 0) b = $urandom_range(0, 255);
      else begin
        b = pick_tbl[$urandom_range(0, 13)];
        if (b == 'hB0) b = b + $urandom_range(0, 7);
        if (b == 'h05) b = $urandom_range(0, 31);
      end
      if (m_left > 0 && m_op == 'h20 && is_data == 0) b = $urandom_range(0, 3);
      send_byte(is_data, b, hold, fast);
    end
    csn = 1'b1;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
